// File: rtl/jtag_tap_sync.sv
// JTAG TAP responder: oversamples TCK/TMS/TDI on wb_clk_i and runs the 1149.1 TAP with IR, IDCODE, BYPASS and debug-DR strobes.
// Optional TCK deglitch filter enabled by defining JTAG_TAP_SYNC_TCK_FILTER_EN.
module jtag_tap_sync #(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter logic [3:0]  IDCODE_INSTR = 4'h2,
  parameter logic [3:0]  DEBUG_INSTR  = 4'h8,
  parameter logic [3:0]  BYPASS_INSTR = 4'hF
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  input  logic debug_tdo_i,
  output logic tdi_o,
  output logic debug_select_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic test_logic_reset_o
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  logic r_tck_meta, r_tck_sync, r_tck_prev;
  logic r_tms_meta, r_tms_sync;
  logic r_tdi_meta, r_tdi_sync;
  logic w_tck_lvl, w_tck_rise, w_tck_fall;

  tap_state_e  r_state, w_state_next;
  logic [3:0]  r_ir, r_ir_shift;
  logic [31:0] r_idcode_shift;
  logic        r_bypass, r_tdo;
  logic        r_capture_dr, r_shift_dr, r_update_dr;
  logic        w_sel_idcode, w_sel_debug, w_sel_bypass, w_dr_tdo;

  // NOTE: every sequential process uses <= so all flops see pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tck_meta <= 1'b0;  r_tck_sync <= 1'b0;  r_tck_prev <= 1'b0;
      r_tms_meta <= 1'b0;  r_tms_sync <= 1'b0;
      r_tdi_meta <= 1'b0;  r_tdi_sync <= 1'b0;
    end else begin
      r_tck_meta <= tck_pad_i;  r_tck_sync <= r_tck_meta;  r_tck_prev <= w_tck_lvl;
      r_tms_meta <= tms_pad_i;  r_tms_sync <= r_tms_meta;
      r_tdi_meta <= tdi_pad_i;  r_tdi_sync <= r_tdi_meta;
    end
  end

`ifdef JTAG_TAP_SYNC_TCK_FILTER_EN
  // The filtered level only follows sync_tck once it has been stable for two samples.
  logic r_tck_hold;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_tck_hold <= 1'b0;
    else          r_tck_hold <= r_tck_sync;
  end
  assign w_tck_lvl = (r_tck_sync == r_tck_hold) ? r_tck_sync : r_tck_prev;
`else
  assign w_tck_lvl = r_tck_sync;
`endif

  assign w_tck_rise = w_tck_lvl & ~r_tck_prev;
  assign w_tck_fall = ~w_tck_lvl & r_tck_prev;

  // NOTE: next state defaults to the current one first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (w_tck_rise) begin
      case (r_state)
        TEST_LOGIC_RESET: w_state_next = r_tms_sync ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    w_state_next = r_tms_sync ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        w_state_next = r_tms_sync ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       w_state_next = r_tms_sync ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:         w_state_next = r_tms_sync ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:         w_state_next = r_tms_sync ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         w_state_next = r_tms_sync ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:         w_state_next = r_tms_sync ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        w_state_next = r_tms_sync ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        w_state_next = r_tms_sync ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       w_state_next = r_tms_sync ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:         w_state_next = r_tms_sync ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:         w_state_next = r_tms_sync ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         w_state_next = r_tms_sync ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:         w_state_next = r_tms_sync ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        w_state_next = r_tms_sync ? SELECT_DR : RUN_TEST_IDLE;
        default:          w_state_next = TEST_LOGIC_RESET;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= TEST_LOGIC_RESET;
    else          r_state <= w_state_next;
  end

  assign w_sel_idcode = (r_ir == IDCODE_INSTR);
  assign w_sel_debug  = (r_ir == DEBUG_INSTR);
  assign w_sel_bypass = (r_ir == BYPASS_INSTR) || (!w_sel_idcode && !w_sel_debug);

  always_comb begin
    w_dr_tdo = debug_tdo_i;
    if (w_sel_bypass)      w_dr_tdo = r_bypass;
    else if (w_sel_idcode) w_dr_tdo = r_idcode_shift[0];
  end

  // Rise is checked first, so a coincident fall (TCK too narrow) is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ir           <= IDCODE_INSTR;
      r_ir_shift     <= 4'h0;
      r_idcode_shift <= 32'h0;
      r_bypass       <= 1'b0;
      r_tdo          <= 1'b0;
    end else if (w_tck_rise) begin
      case (r_state)
        CAPTURE_IR: r_ir_shift <= 4'b0101;
        SHIFT_IR:   r_ir_shift <= {r_tdi_sync, r_ir_shift[3:1]};
        CAPTURE_DR: begin
          r_idcode_shift <= IDCODE_VALUE;
          r_bypass       <= 1'b0;
        end
        SHIFT_DR: begin
          r_idcode_shift <= {r_tdi_sync, r_idcode_shift[31:1]};
          r_bypass       <= r_tdi_sync;
        end
        default: ;
      endcase
      if (w_state_next == TEST_LOGIC_RESET) r_ir <= IDCODE_INSTR;
    end else if (w_tck_fall) begin
      case (r_state)
        UPDATE_IR: begin
          r_ir  <= r_ir_shift;
          r_tdo <= 1'b0;
        end
        SHIFT_IR: r_tdo <= r_ir_shift[0];
        SHIFT_DR: r_tdo <= w_dr_tdo;
        default:  r_tdo <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_capture_dr <= 1'b0;
      r_shift_dr   <= 1'b0;
      r_update_dr  <= 1'b0;
    end else begin
      r_capture_dr <= w_tck_rise && (r_state == CAPTURE_DR) && w_sel_debug;
      r_shift_dr   <= w_tck_rise && (r_state == SHIFT_DR)   && w_sel_debug;
      r_update_dr  <= w_tck_fall && (r_state == UPDATE_DR)  && w_sel_debug;
    end
  end

  assign tdo_pad_o          = r_tdo;
  assign tdi_o              = r_tdi_sync;
  assign debug_select_o     = w_sel_debug;
  assign capture_dr_o       = r_capture_dr;
  assign shift_dr_o         = r_shift_dr;
  assign update_dr_o        = r_update_dr;
  assign test_logic_reset_o = (r_state == TEST_LOGIC_RESET);

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: expected TDO bits are queued as stimulus is driven and popped after each TCK fall.
// Exercises the glitch filter when JTAG_TAP_SYNC_TCK_FILTER_EN is defined.
module tb_jtag_tap_sync;

`ifdef JTAG_TAP_SYNC_TCK_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int HALF = 6;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic tck_pad_i = 1'b0, tms_pad_i = 1'b1, tdi_pad_i = 1'b0, debug_tdo_i = 1'b0;
  logic tdo_pad_o, tdi_o, debug_select_o, capture_dr_o, shift_dr_o, update_dr_o, test_logic_reset_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_cap = 0, n_shift = 0, n_upd = 0, n_overlap = 0;
  logic exp_q[$];

  jtag_tap_sync dut (
    .wb_clk_i           (wb_clk_i),
    .wb_rst_i           (wb_rst_i),
    .tck_pad_i          (tck_pad_i),
    .tms_pad_i          (tms_pad_i),
    .tdi_pad_i          (tdi_pad_i),
    .tdo_pad_o          (tdo_pad_o),
    .debug_tdo_i        (debug_tdo_i),
    .tdi_o              (tdi_o),
    .debug_select_o     (debug_select_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .test_logic_reset_o (test_logic_reset_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Strobe cycle counters; a strobe wider than one cycle shows up as an extra count.
  always @(negedge wb_clk_i) begin
    if (capture_dr_o) n_cap++;
    if (shift_dr_o)   n_shift++;
    if (update_dr_o)  n_upd++;
    if ((int'(capture_dr_o) + int'(shift_dr_o) + int'(update_dr_o)) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full TCK period starting and ending on a wb_clk_i falling edge.
  task automatic jtag_clk(input logic tms, input logic tdi, input bit chk);
    tms_pad_i = tms;
    tdi_pad_i = tdi;
    tck_pad_i = 1'b1;
    repeat (HALF) @(negedge wb_clk_i);
    tck_pad_i = 1'b0;
    repeat (HALF) @(negedge wb_clk_i);
    if (chk) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL scoreboard: observed=empty expected=entry");
      end else begin
        check("tdo", {31'h0, tdo_pad_o}, {31'h0, exp_q.pop_front()});
      end
    end
  endtask

  // From RUN_TEST_IDLE back to RUN_TEST_IDLE, checking the captured 0101 shifting out.
  task automatic ir_scan(input logic [3:0] val);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) jtag_clk(i == 3, val[i], 1'b1);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] idcode = 32'h149511C3;
    logic [9:0]  dbg_pat = 10'b1011001110;
    logic [7:0]  byp_data = 8'hA5;
    int cap0, shift0, upd0, ovl0;

    // Reset with TCK idle
    repeat (10) @(negedge wb_clk_i);
    check("rst_tlr", {31'h0, test_logic_reset_o}, 32'h1);
    check("rst_tdo", {31'h0, tdo_pad_o}, 32'h0);
    check("rst_dsel", {31'h0, debug_select_o}, 32'h0);
    check("rst_strobes", {29'h0, capture_dr_o, shift_dr_o, update_dr_o}, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    tdi_pad_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("tdi_o_hi", {31'h0, tdi_o}, 32'h1);
    tdi_pad_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("tdi_o_lo", {31'h0, tdi_o}, 32'h0);

    // IDCODE read straight out of reset
    cap0 = n_cap; shift0 = n_shift; upd0 = n_upd;
    jtag_clk(1'b0, 1'b0, 1'b0);
    check("tlr_left", {31'h0, test_logic_reset_o}, 32'h0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(idcode[i]);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 32; i++) jtag_clk(1'b0, 1'b0, 1'b1);
    jtag_clk(1'b1, 1'b0, 1'b1);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    check("idcode_no_strobes", n_cap + n_shift + n_upd - cap0 - shift0 - upd0, 0);

    // Load DEBUG instruction
    ir_scan(4'h8);
    check("dsel_after_ir8", {31'h0, debug_select_o}, 32'h1);

    // 10-bit debug DR scan with toggling debug_tdo_i
    cap0 = n_cap; shift0 = n_shift; upd0 = n_upd; ovl0 = n_overlap;
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      debug_tdo_i = dbg_pat[j];
      exp_q.push_back(dbg_pat[j]);
      jtag_clk(1'b0, j[0], 1'b1);
`ifdef JTAG_TAP_SYNC_TCK_FILTER_EN
      if (j == 4) begin
        tck_pad_i = 1'b1;
        @(negedge wb_clk_i);
        tck_pad_i = 1'b0;
        repeat (10) @(negedge wb_clk_i);
      end
`endif
    end
    debug_tdo_i = 1'b1;
    exp_q.push_back(1'b0);
    jtag_clk(1'b1, 1'b0, 1'b1);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    debug_tdo_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    check("dbg_capture_cnt", n_cap - cap0, 1);
    check("dbg_shift_cnt", n_shift - shift0, 10);
    check("dbg_update_cnt", n_upd - upd0, 1);
    check("dbg_overlap", n_overlap - ovl0, 0);

    // Unlisted opcode selects BYPASS
    ir_scan(4'h5);
    check("dsel_after_ir5", {31'h0, debug_select_o}, 32'h0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(byp_data[i]);
    jtag_clk(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) jtag_clk(1'b0, byp_data[i], 1'b1);
    jtag_clk(1'b1, 1'b1, 1'b0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);

    // TLR recovery from SHIFT_DR with DEBUG loaded
    ir_scan(4'h8);
    check("dsel_before_tlr", {31'h0, debug_select_o}, 32'h1);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) jtag_clk(1'b1, 1'b0, 1'b0);
    check("tlr_after_4", {31'h0, test_logic_reset_o}, 32'h0);
    tms_pad_i = 1'b1;
    tck_pad_i = 1'b1;
    repeat (LAT - 1) @(negedge wb_clk_i);
    check("tlr_5th_early", {31'h0, test_logic_reset_o}, 32'h0);
    @(negedge wb_clk_i);
    check("tlr_5th", {31'h0, test_logic_reset_o}, 32'h1);
    check("tlr_ir_idcode", {31'h0, debug_select_o}, 32'h0);
    repeat (HALF - LAT) @(negedge wb_clk_i);
    tck_pad_i = 1'b0;
    repeat (HALF) @(negedge wb_clk_i);
    check("tlr_tdo", {31'h0, tdo_pad_o}, 32'h0);

    // Reset in the middle of an IDCODE shift
    jtag_clk(1'b0, 1'b0, 1'b0);
    jtag_clk(1'b1, 1'b0, 1'b0);
    jtag_clk(1'b0, 1'b0, 1'b0);
    exp_q.push_back(idcode[0]);
    jtag_clk(1'b0, 1'b0, 1'b1);
    check("pre_rst_tlr", {31'h0, test_logic_reset_o}, 32'h0);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("midrst_tdo", {31'h0, tdo_pad_o}, 32'h0);
    check("midrst_tlr", {31'h0, test_logic_reset_o}, 32'h1);
    wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    check("post_rst_tlr", {31'h0, test_logic_reset_o}, 32'h1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sync.md
Name: jtag_tap_sync

Overview:
- JTAG TAP responder for the TMS/TCK/TDI/TDO pins that the simulation JTAG VPI initiator drives. It is the device end of that link.
- Oversamples the JTAG pins on the system clock and runs the IEEE 1149.1 16-state TAP controller.
- Provides a 4-bit IR, IDCODE and BYPASS data registers, and a debug-DR strobe interface for the debug unit, so the whole debug path runs in one clock domain.

Parameters:
- IDCODE_VALUE, 32'h149511C3, value loaded into the IDCODE DR at CAPTURE_DR.
- IDCODE_INSTR, 4'h2, IR opcode selecting IDCODE; also the IR reset value.
- DEBUG_INSTR, 4'h8, IR opcode selecting the external debug DR.
- BYPASS_INSTR, 4'hF, explicit BYPASS opcode. Every unlisted opcode also selects BYPASS.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- tck_pad_i  in  1  JTAG clock (asynchronous to wb_clk_i).
- tms_pad_i  in  1  JTAG mode select.
- tdi_pad_i  in  1  JTAG data in.
- tdo_pad_o  out  1  JTAG data out.
- debug_tdo_i  in  1  serial output of the debug DR.
- tdi_o  out  1  synchronized TDI, for the debug DR.
- debug_select_o  out  1  level: IR == DEBUG_INSTR.
- capture_dr_o  out  1  one-cycle strobe.
- shift_dr_o  out  1  one-cycle strobe.
- update_dr_o  out  1  one-cycle strobe.
- test_logic_reset_o  out  1  level: TAP state is TEST_LOGIC_RESET.

Behaviour:
- Synchronizers: tck, tms and tdi each pass through a 2-flop synchronizer. tck_prev is registered after the synchronizer.
  - tck_rise = sync_tck & ~tck_prev.
  - tck_fall = ~sync_tck & tck_prev.
  - Latency from pad edge to strobe is 3 wb_clk_i cycles.
- Pin timing requirement: TCK high and low times of at least 3 wb_clk_i cycles each. Slower TCK is always legal.
- TAP states: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR.
  - Transitions follow the standard 1149.1 graph, evaluated with sync_tms on tck_rise only.
  - Five consecutive tck_rise with tms=1 reach TEST_LOGIC_RESET from any state.
- Actions on tck_rise, keyed on the current (pre-transition) state:
  - CAPTURE_IR: ir_shift <= 4'b0101.
  - SHIFT_IR: ir_shift <= {sync_tdi, ir_shift[3:1]}.
  - CAPTURE_DR: idcode_shift <= IDCODE_VALUE; bypass_reg <= 0.
  - SHIFT_DR: idcode_shift shifts right with tdi in at bit 31; bypass_reg <= sync_tdi.
- Actions on tck_fall:
  - UPDATE_IR: ir <= ir_shift.
  - SHIFT_IR: tdo_pad_o <= ir_shift[0].
  - SHIFT_DR: tdo_pad_o <= selected DR bit:
    - idcode_shift[0] when IDCODE is selected;
    - debug_tdo_i when DEBUG is selected;
    - bypass_reg otherwise.
  - Any other state: tdo_pad_o <= 0.
- Debug strobes are asserted only when debug_select_o=1:
  - capture_dr_o and shift_dr_o assert for exactly the tck_rise cycle while state is CAPTURE_DR / SHIFT_DR.
  - update_dr_o asserts for exactly the tck_fall cycle while state is UPDATE_DR.
  - They are never asserted in the same cycle as one another.
- Entering TEST_LOGIC_RESET forces ir <= IDCODE_INSTR on the same cycle.
- tdi_o = sync_tdi, combinational from the synchronizer output.
- Reset values (also apply if reset is asserted mid-scan; the partial shift is discarded):
  - state = TEST_LOGIC_RESET, ir = IDCODE_INSTR, ir_shift = 0, idcode_shift = 0, bypass_reg = 0.
  - tdo_pad_o = 0, all strobes = 0, debug_select_o = 0, test_logic_reset_o = 1.
  - Synchronizer flops = 0.
- If a tck_rise and a tck_fall would coincide (TCK narrower than the timing requirement), only the tck_rise is processed. Behaviour in that case is otherwise undefined.

Optional Feature:
- Macro JTAG_TAP_SYNC_TCK_FILTER_EN.
- When defined: sync_tck must hold the same value for 2 consecutive cycles before a filtered tck level changes. Edges are detected on the filtered level.
  - Pad-to-strobe latency becomes 4 cycles.
  - Single-cycle TCK glitches are ignored.
  - Minimum high/low time becomes 4 cycles.
- When undefined: no filter, latency 3 cycles.

Test Plan:
- Reset: assert wb_rst_i for 10 cycles with tck idle -> state TEST_LOGIC_RESET, test_logic_reset_o=1, tdo_pad_o=0, debug_select_o=0, all strobes 0.
- TLR recovery: drive into SHIFT_DR, then 5 TCK pulses with tms=1 -> test_logic_reset_o=1 after the 5th rise + 3 cycles, and ir reads IDCODE_INSTR.
- IDCODE read: from reset with tms sequence 0,1,0,0, then 32 shift clocks -> tdo_pad_o yields 0x149511C3 LSB first.
- IR scan: shift IR value 4'h8 -> tdo_pad_o emits 1,0,1,0; after UPDATE_IR, debug_select_o=1.
- Bypass: load IR=4'h5 (unlisted opcode), shift 0xA5 LSB first over 9 clocks -> tdo_pad_o shows 0 then 1,0,1,0,0,1,0,1.
- Debug DR: with IR=DEBUG_INSTR, do a 10-bit DR scan with debug_tdo_i toggling -> exactly 1 capture_dr_o, 10 shift_dr_o and 1 update_dr_o pulse, and tdo_pad_o follows debug_tdo_i on each tck_fall. With the macro defined, a 1-cycle TCK glitch produces no strobe.
